// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 encodings and access-size helpers for the load/store unit.
// No logic of its own; imported by lsu and lsu_align.
// Size and misalignment are derived from funct3 alone so that decode and checking always agree.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LD  = 3'b011;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_LWU = 3'b110;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;
  localparam logic [2:0] LSU_SD  = 3'b011;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] lsu_size(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

  // funct3 111 has no legal access, so it reports as misaligned.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/mask placement and load extraction with sign/zero extension.
// Purely combinational, zero latency.
// No handshake; the caller qualifies inputs and outputs.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic [2:0]        st_off,
  input  logic [3:0]        st_size,
  input  logic [XLEN-1:0]   st_wdata,
  output logic [XLEN-1:0]   st_data,
  output logic [MASK_W-1:0] st_mask,
  input  logic [XLEN-1:0]   ld_rdata,
  input  logic [2:0]        ld_off,
  input  logic [2:0]        ld_funct3,
  output logic [XLEN-1:0]   ld_data
);

  logic [MASK_W-1:0] base_mask;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    st_data = st_wdata << {st_off, 3'b000};
    // Shifting all-ones by the size leaves exactly size low bits clear; invert to get them set.
    base_mask = ~({MASK_W{1'b1}} << st_size);
    st_mask   = base_mask << st_off;
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      LSU_LB:  ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LSU_LBU: ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LSU_LH:  ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LSU_LHU: ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LSU_LW:  ld_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LSU_LWU: ld_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding memory port with alignment, masking and load extension.
// Latency: done 3 cycles after accept when memory is immediately ready; 1 cycle for misaligned.
// Backpressure: lsu_ready only in IDLE; request held stable until mem_req_ready.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  lsu_state_e      state_q, state_d;
  mem_req_t        req_q, req_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic              accept;
  logic              misaligned;
  logic [3:0]        size;
  logic [XLEN-1:0]   st_data;
  logic [MASK_W-1:0] st_mask;
  logic [XLEN-1:0]   ld_data;

  assign accept     = lsu_valid && lsu_ready;
  assign size       = lsu_size(lsu_funct3);
  assign misaligned = lsu_misaligned(lsu_funct3, lsu_addr[2:0]);

  lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
    .st_off    (lsu_addr[2:0]),
    .st_size   (size),
    .st_wdata  (lsu_wdata),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .ld_rdata  (mem_resp_rdata),
    .ld_off    (off_q),
    .ld_funct3 (funct3_q),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept)         state_d = misaligned ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (mem_req_ready)  state_d = LSU_WAIT;
      LSU_WAIT: if (mem_resp_valid) state_d = LSU_DONE;
      default:                      state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    lsu_ready     = (state_q == LSU_IDLE);
    mem_req_valid = (state_q == LSU_REQ);
    lsu_done      = (state_q == LSU_DONE);
  end

  // Result registers only change on the way into DONE, so they hold between completions.
  always_comb begin
    req_d    = req_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      req_d.we    = lsu_we;
      req_d.addr  = {lsu_addr[XLEN-1:3], 3'b000};
      req_d.wdata = lsu_we ? st_data : '0;
      req_d.wmask = lsu_we ? st_mask : '0;
      funct3_d    = lsu_funct3;
      off_d       = lsu_addr[2:0];
      if (misaligned) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
    if (state_q == LSU_WAIT && mem_resp_valid) begin
      err_d   = 1'b0;
      rdata_d = req_q.we ? '0 : ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      req_q    <= req_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;
  assign lsu_rdata     = rdata_q;
  assign lsu_err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-level memory model predicts responses, a memory responder checks requests.
`timescale 1ns/1ps
module tb_lsu;
  localparam int XLEN = 64;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lsu_valid, lsu_ready, lsu_we, lsu_done, lsu_err;
  logic [2:0]        lsu_funct3;
  logic [XLEN-1:0]   lsu_addr, lsu_wdata, lsu_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [XLEN-1:0]   mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [MASK_W-1:0] mem_req_wmask;

  always #5 clk = ~clk;

  lsu #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   hs_cnt = 0;
  int   rdly_cfg = 0;
  int   sdly_cfg = 0;
  req_t last_req;
  req_t req_q[$];
  exp_t exp_q[$];

  logic [7:0]  mb [logic [63:0]];
  logic [63:0] pm [logic [63:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [63:0] a);
    return 8'(a * 64'd37 + (a >> 5));
  endfunction

  function automatic logic [7:0] model_rd(input logic [63:0] a);
    if (mb.exists(a)) return mb[a];
    return init_byte(a);
  endfunction

  function automatic logic [63:0] phys_rd(input logic [63:0] al);
    logic [63:0] w;
    if (pm.exists(al)) return pm[al];
    for (int i = 0; i < 8; i++) w[8*i +: 8] = init_byte(al + 64'(i));
    return w;
  endfunction

  task automatic preload(input logic [63:0] al, input logic [63:0] d);
    for (int i = 0; i < 8; i++) mb[al + 64'(i)] = d[8*i +: 8];
    pm[al] = d;
  endtask

  // Memory responder: holds ready low for rdly_cfg cycles, answers sdly_cfg cycles after the handshake.
  initial begin
    bit          seen, pend, unstable;
    int          rcnt, scnt;
    logic [63:0] prd, w;
    req_t        snap, cur, e;
    seen = 0; pend = 0; unstable = 0; rcnt = 0; scnt = 0; prd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (pend) begin
        if (scnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = prd;
          pend = 0;
        end else scnt--;
      end else if (mem_req_valid && rst_n) begin
        cur = '{mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask};
        if (!seen) begin
          seen = 1; rcnt = rdly_cfg; unstable = 0; snap = cur;
        end else if (cur != snap) unstable = 1;
        if (rcnt == 0) begin
          mem_req_ready = 1'b1;
          seen = 0;
          hs_cnt++;
          last_req = cur;
          check64("req_stable", 64'(unstable), 64'd0);
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req: got addr %h with no request expected", cur.addr);
          end else begin
            e = req_q.pop_front();
            check64("req_we", 64'(cur.we), 64'(e.we));
            check64("req_addr", cur.addr, e.addr);
            check64("req_wdata", cur.wdata, e.wdata);
            check64("req_wmask", 64'(cur.wmask), 64'(e.wmask));
          end
          if (cur.we) begin
            w = phys_rd(cur.addr);
            for (int i = 0; i < 8; i++) if (cur.wmask[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
            pm[cur.addr] = w;
            prd = {$urandom, $urandom};
          end else prd = phys_rd(cur.addr);
          pend = 1; scnt = sdly_cfg;
        end else rcnt--;
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (lsu_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got lsu_done=1 at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check64("lsu_rdata", lsu_rdata, e.rdata);
          check64("lsu_err", 64'(lsu_err), 64'(e.err));
          if (e.lat >= 0) check64("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input int rdly, input int sdly, output int start);
    int          size, off;
    bit          mis;
    logic [63:0] al, v;
    exp_t        e;
    req_t        r;
    @(negedge clk);
    check64("lsu_ready_idle", 64'(lsu_ready), 64'd1);
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    al   = addr & ~64'h7;
    mis  = (f3 == 3'b111) || ((off % size) != 0);
    e.acc = cyc; e.err = mis; e.rdata = '0;
    if (mis) e.lat = 1;
    else begin
      e.lat = 3 + rdly + sdly;
      r.we = we; r.addr = al; r.wdata = '0; r.wmask = '0;
      if (we) begin
        for (int j = 0; j < size; j++) begin
          mb[al + 64'(off + j)] = wd[8*j +: 8];
          r.wmask[off + j] = 1'b1;
        end
        for (int i = 0; i + off < 8; i++) r.wdata[8*(i + off) +: 8] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int j = 0; j < size; j++) v[8*j +: 8] = model_rd(addr + 64'(j));
        if (!f3[2] && size < 8 && v[8*size-1])
          for (int k = 8 * size; k < 64; k++) v[k] = 1'b1;
        e.rdata = v;
      end
      req_q.push_back(r);
    end
    exp_q.push_back(e);
    rdly_cfg = rdly; sdly_cfg = sdly;
    start = done_cnt;
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(negedge clk); #1;
    lsu_valid = 1'b0; lsu_we = $urandom_range(0, 1); lsu_funct3 = 3'($urandom);
    lsu_addr = {$urandom, $urandom}; lsu_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int start);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = !lsu_ready;
    while (done_cnt == start && n < 300) begin
      @(negedge clk); #1;
      if (lsu_ready) busy_ok = 0;
      n++;
    end
    check64("done_timeout", 64'(done_cnt != start), 64'd1);
    check64("ready_busy", 64'(busy_ok), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check64({tag, "_done"}, 64'(lsu_done), 64'd0);
    check64({tag, "_err"}, 64'(lsu_err), 64'd0);
    check64({tag, "_rdata"}, lsu_rdata, 64'd0);
    check64({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    check64({tag, "_req_we"}, 64'(mem_req_we), 64'd0);
    check64({tag, "_req_addr"}, mem_req_addr, 64'd0);
    check64({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
    check64({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion of the run expected $finish before 500us");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, hs0;
    logic        we;
    logic [2:0]  f3;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(negedge clk);
    #1 check_zero_outputs("por");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check64("ready_after_reset", 64'(lsu_ready), 64'd1);

    preload(64'h8000_0000, 64'h1122_3344_8566_7788);
    issue(1'b0, 3'b000, 64'h8000_0003, '0, 0, 0, s); wait_done(s);
    check64("lb_rdata", lsu_rdata, 64'hFFFF_FFFF_FFFF_FF85);
    check64("lb_req_addr", last_req.addr, 64'h8000_0000);
    check64("lb_req_wmask", 64'(last_req.wmask), 64'h00);

    issue(1'b0, 3'b110, 64'h8000_0004, '0, 0, 0, s); wait_done(s);
    check64("lwu_rdata", lsu_rdata, 64'h0000_0000_1122_3344);

    issue(1'b1, 3'b001, 64'h8000_0006, 64'hABCD, 0, 1, s); wait_done(s);
    check64("sh_wdata", last_req.wdata, 64'hABCD_0000_0000_0000);
    check64("sh_wmask", 64'(last_req.wmask), 64'hC0);
    check64("sh_rdata", lsu_rdata, 64'd0);

    hs0 = hs_cnt;
    issue(1'b0, 3'b010, 64'h8000_0002, '0, 0, 0, s); wait_done(s);
    check64("mis_err_hold", 64'(lsu_err), 64'd1);
    check64("mis_no_request", 64'(hs_cnt - hs0), 64'd0);

    issue(1'b0, 3'b011, 64'h8000_0000, '0, 5, 0, s); wait_done(s);
    check64("bp_rdata", lsu_rdata, 64'hABCD_3344_8566_7788);

    issue(1'b0, 3'b011, 64'h8000_0008, '0, 0, 6, s);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
    exp_q.delete(); req_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check64("stray_no_done", 64'(done_cnt - s), 64'd0);
    check64("stray_rdata", lsu_rdata, 64'd0);
    check64("stray_err", 64'(lsu_err), 64'd0);
    issue(1'b0, 3'b011, 64'h8000_0008, '0, 0, 0, s); wait_done(s);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if (we) f3 = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 3));
      else    f3 = 3'($urandom_range(0, 7));
      issue(we, f3, 64'h8000_0000 + 64'($urandom_range(0, 47)), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), s);
      wait_done(s);
    end

    repeat (3) @(negedge clk);
    check64("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
